// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types and constants for the OLED power sequencer
package oled_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_PMOD_ON,
        ST_RST_LO,
        ST_RST_HI,
        ST_CMD,
        ST_VBAT_ON,
        ST_DISP_ON,
        ST_ON,
        ST_PD_DISP,
        ST_PD_VBAT,
        ST_PD_PMOD,
        ST_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_BUS,
        PH_WAIT,
        PH_FETCH
    } seq_phase_t;

    localparam logic [1:0] OLED_ADDR_CMD = 2'b00;
    localparam logic [1:0] OLED_ADDR_PWR = 2'b11;

    localparam int PWR_VCCEN  = 2;
    localparam int PWR_PMODEN = 1;
    localparam int PWR_RESN   = 0;

    localparam logic [2:0] PWR_B_VCCEN  = 3'b001 << PWR_VCCEN;
    localparam logic [2:0] PWR_B_PMODEN = 3'b001 << PWR_PMODEN;
    localparam logic [2:0] PWR_B_RESN   = 3'b001 << PWR_RESN;

    localparam logic [7:0]  CMD_DISP_ON  = 8'hAF;
    localparam logic [7:0]  CMD_DISP_OFF = 8'hAE;
    localparam logic [31:0] CMD_END      = 32'hF000_0000;

    // Power register word: mask selects which bits the slave updates, value gives their level.
    function automatic logic [31:0] pwr_word(input logic [2:0] mask, input logic [2:0] value);
        pwr_word = {9'd0, mask, 1'b0, value, 16'd0};
    endfunction

endpackage

// File: rtl/oled_cmd_rom.sv
// rtl/oled_cmd_rom.sv - registered-read init-command ROM, contents supplied as a packed image
module oled_cmd_rom #(
    parameter int                      ROM_AW   = 4,
    parameter logic [(32<<ROM_AW)-1:0] ROM_INIT = '0
) (
    input  logic              i_clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [31:0]       o_data
);

    always_ff @(posedge i_clk) begin
        o_data <= ROM_INIT[{i_addr, 5'd0} +: 32];
    end

endmodule

// File: rtl/oled_pwr_seq.sv
// rtl/oled_pwr_seq.sv - Wishbone master sequencing OLED power-up, init commands and power-down
module oled_pwr_seq
    import oled_pkg::*;
#(
    parameter int                      ROM_AW   = 4,
    parameter int                      DLY_W    = 24,
    parameter logic [DLY_W-1:0]        DLY_VDD  = 24'd100000,
    parameter logic [DLY_W-1:0]        DLY_RST  = 24'd1000,
    parameter logic [DLY_W-1:0]        DLY_VBAT = 24'd10000000,
    parameter logic [7:0]              TMO      = 8'd255,
    parameter logic [(32<<ROM_AW)-1:0] ROM_INIT = {(1<<ROM_AW){CMD_END}}
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [1:0]  o_addr,
    output logic [31:0] o_data,
    input  logic        i_ack,
    input  logic        i_stall,
    input  logic        i_int,
    output logic        o_busy,
    output logic        o_on,
    output logic        o_err
);

    localparam logic [DLY_W-1:0] GUARD_CYC = DLY_W'(4);

    seq_state_t        state_q, state_d, step_next;
    seq_phase_t        phase_q, phase_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, err_q, err_d;
    logic [1:0]        addr_q, addr_d, step_addr;
    logic [31:0]       data_q, data_d, step_data, rom_q;
    logic [DLY_W-1:0]  dly_q, dly_d, step_dly;
    logic [7:0]        tmo_q, tmo_d;
    logic [ROM_AW:0]   idx_q, idx_d;

    oled_cmd_rom #(
        .ROM_AW   (ROM_AW),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .i_clk  (i_clk),
        .i_addr (idx_q[ROM_AW-1:0]),
        .o_data (rom_q)
    );

    // What each step writes, how long it waits afterwards, and where it goes next.
    always_comb begin
        step_addr = OLED_ADDR_PWR;
        step_data = '0;
        step_dly  = '0;
        step_next = ST_OFF;
        case (state_q)
            ST_PMOD_ON: begin
                step_data = pwr_word(PWR_B_PMODEN | PWR_B_RESN, PWR_B_PMODEN);
                step_dly  = DLY_VDD;
                step_next = ST_RST_LO;
            end
            ST_RST_LO: begin
                step_data = pwr_word(PWR_B_RESN, 3'b000);
                step_dly  = DLY_RST;
                step_next = ST_RST_HI;
            end
            ST_RST_HI: begin
                step_data = pwr_word(PWR_B_RESN, PWR_B_RESN);
                step_dly  = DLY_RST;
                step_next = ST_CMD;
            end
            ST_CMD: begin
                step_addr = OLED_ADDR_CMD;
                step_data = rom_q;
                step_next = idx_q[ROM_AW] ? ST_VBAT_ON : ST_CMD;
            end
            ST_VBAT_ON: begin
                step_data = pwr_word(PWR_B_VCCEN, PWR_B_VCCEN);
                step_dly  = DLY_VBAT;
                step_next = ST_DISP_ON;
            end
            ST_DISP_ON: begin
                step_addr = OLED_ADDR_CMD;
                step_data = {24'd0, CMD_DISP_ON};
                step_next = ST_ON;
            end
            ST_PD_DISP: begin
                step_addr = OLED_ADDR_CMD;
                step_data = {24'd0, CMD_DISP_OFF};
                step_next = ST_PD_VBAT;
            end
            ST_PD_VBAT: begin
                step_data = pwr_word(PWR_B_VCCEN, 3'b000);
                step_dly  = DLY_VBAT;
                step_next = ST_PD_PMOD;
            end
            ST_PD_PMOD: begin
                step_data = pwr_word(PWR_B_PMODEN, 3'b000);
                step_next = ST_OFF;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_OFF, ST_ERR: begin
                if (i_start) begin
                    state_d = ST_PMOD_ON;
                    phase_d = PH_ISSUE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ON: begin
                if (i_stop) begin
                    state_d = ST_PD_DISP;
                    phase_d = PH_ISSUE;
                end
            end
            default: begin
                case (phase_q)
                    PH_FETCH: phase_d = PH_ISSUE;
                    PH_ISSUE: begin
                        // The list terminator is consumed without a bus write.
                        if (state_q == ST_CMD && rom_q == CMD_END) begin
                            state_d = ST_VBAT_ON;
                        end else begin
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            addr_d  = step_addr;
                            data_d  = step_data;
                            tmo_d   = '0;
                            phase_d = PH_BUS;
                        end
                    end
                    PH_BUS: begin
                        if (!i_stall) stb_d = 1'b0;
                        if (i_ack) begin
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            phase_d = PH_WAIT;
                            dly_d   = (addr_q == OLED_ADDR_CMD) ? GUARD_CYC - 1'b1
                                                                : step_dly - 1'b1;
                            if (state_q == ST_CMD) idx_d = idx_q + 1'b1;
                            if (state_q == ST_PD_PMOD) state_d = ST_OFF;
                        end else if (tmo_q == TMO - 8'd1) begin
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            err_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            tmo_d = tmo_q + 8'd1;
                        end
                    end
                    PH_WAIT: begin
                        // Command writes also wait for the slave to report idle again.
                        if (dly_q != '0) begin
                            dly_d = dly_q - 1'b1;
                        end else if (addr_q != OLED_ADDR_CMD || i_int) begin
                            state_d = step_next;
                            phase_d = (step_next == ST_CMD) ? PH_FETCH : PH_ISSUE;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_OFF;
            phase_q <= PH_ISSUE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dly_q   <= '0;
            tmo_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign o_cyc  = cyc_q;
    assign o_stb  = stb_q;
    assign o_we   = 1'b1;
    assign o_addr = addr_q;
    assign o_data = data_q;
    assign o_err  = err_q;
    assign o_on   = (state_q == ST_ON);
    assign o_busy = !(state_q inside {ST_OFF, ST_ON, ST_ERR});

endmodule
